// File: rtl/exp_shifter_gen2.sv
// Block-exponent normaliser: IIR-averages the FFT block exponent, shifts I/Q by the
// correction with rounding/saturation, buffers into a FIFO. Optional: SAT_COUNT_EN.

module exp_shifter_gen2_lane #(
  parameter int DW        = 16,
  parameter int MAX_SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     x,
  input  logic signed [5:0] shift,
  output logic [DW-1:0]     y,
  output logic              clip
);
  localparam int W = DW + MAX_SHIFT + 1;
  localparam logic signed [W-1:0] MAXV = {{(W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [W-1:0] xw, rnd, wide, wide_q;
  logic [5:0] mag;

  // wide intermediate so left shifts and the round-half-up add never wrap
  always_comb begin
    xw  = W'($signed(x));
    mag = 6'(-shift);
    rnd = '0;
    if (shift[5]) begin
      rnd  = W'(1) <<< (mag - 6'd1);
      wide = (xw + rnd) >>> mag;
    end else begin
      wide = xw <<< shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wide_q <= '0;
      y      <= '0;
      clip   <= 1'b0;
    end else begin
      wide_q <= wide;
      if (wide_q > MAXV) begin
        y    <= MAXV[DW-1:0];
        clip <= 1'b1;
      end else if (wide_q < MINV) begin
        y    <= MINV[DW-1:0];
        clip <= 1'b1;
      end else begin
        y    <= wide_q[DW-1:0];
        clip <= 1'b0;
      end
    end
  end
endmodule

module exp_shifter_gen2 #(
  parameter int DATA_WIDTH      = 16,
  parameter int BIN_WIDTH       = 7,
  parameter int EXP_WIDTH       = 5,
  parameter int MAX_SHIFT       = 7,
  parameter int HEAD_ROOM       = 2,
  parameter int FRAC_BITS       = 8,
  parameter int FIFO_ADDR_WIDTH = 5,
  localparam int TU = 1 + EXP_WIDTH + BIN_WIDTH
) (
  input  logic                    clk,
  input  logic                    sync_reset_n,
  input  logic                    s_axis_tvalid,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TU-1:0]           s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [3:0]              alpha_shift,
  input  logic                    bypass,
  output logic                    m_axis_tvalid,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [TU-1:0]           m_axis_tuser,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    eob_tag,
  output logic signed [5:0]       cur_shift
`ifdef SAT_COUNT_EN
  ,
  input  logic                    sat_clr,
  output logic [15:0]             sat_count
`endif
);
  localparam int STAGES    = 3;
  localparam int NUM_LANES = 2;
  localparam int AVW       = EXP_WIDTH + FRAC_BITS + 1;
  localparam int DEPTH     = 1 << FIFO_ADDR_WIDTH;

  typedef struct packed {
    logic          last;
    logic [TU-1:0] user;
  } side_t;

  logic [STAGES:0] vld_pipe;
  logic take, wr, rd;
  logic [FIFO_ADDR_WIDTH:0] count;

  assign s_axis_tready = !(count >= (FIFO_ADDR_WIDTH+1)'(DEPTH - 6));
  assign take = s_axis_tvalid & s_axis_tready;

  // stage 1: capture beat plus the block-start controls
  logic [2*DATA_WIDTH-1:0] s1_data;
  side_t s1_side, s2_side, s3_side, s4_side;
  logic s1_byp;
  logic [3:0] s1_alpha;

  // stage 2: shift computation and exponent average
  logic signed [EXP_WIDTH-1:0] exp_s;
  logic signed [AVW:0] ef, avg_base, rnd, avg_next;
  logic signed [AVW-1:0] avg;
  logic signed [6:0] s_raw, s_clamp;
  logic signed [5:0] s_new, shift_reg, s2_shift;
  logic start, primed;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s2_data, y;
  logic [NUM_LANES-1:0] clip;

  always_comb begin
    exp_s    = s1_side.user[BIN_WIDTH +: EXP_WIDTH];
    start    = vld_pipe[0] && (s1_side.user[BIN_WIDTH-1:0] == '0);
    ef       = (AVW+1)'(exp_s) <<< FRAC_BITS;
    avg_base = primed ? (AVW+1)'(avg) : ef;
    rnd      = (avg_base + (AVW+1)'(1 << (FRAC_BITS-1))) >>> FRAC_BITS;
    s_raw    = 7'(exp_s) - 7'(rnd) - 7'(HEAD_ROOM);
    if (s_raw > 7'(MAX_SHIFT))       s_clamp = 7'(MAX_SHIFT);
    else if (s_raw < -7'(MAX_SHIFT)) s_clamp = -7'(MAX_SHIFT);
    else                             s_clamp = s_raw;
    s_new    = s1_byp ? '0 : 6'(s_clamp);
    avg_next = avg_base + ((ef - avg_base) >>> s1_alpha);
  end

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      vld_pipe  <= '0;
      s1_data   <= '0;
      s1_side   <= '0;
      s1_byp    <= 1'b0;
      s1_alpha  <= '0;
      avg       <= '0;
      primed    <= 1'b0;
      shift_reg <= '0;
      s2_shift  <= '0;
      s2_data   <= '0;
      s2_side   <= '0;
      s3_side   <= '0;
      s4_side   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], take};
      if (take) begin
        s1_data  <= s_axis_tdata;
        s1_side  <= '{last: s_axis_tlast, user: s_axis_tuser};
        s1_byp   <= bypass;
        s1_alpha <= (alpha_shift > 4'd8) ? 4'd8 : alpha_shift;
      end
      if (start) begin
        shift_reg <= s_new;
        avg       <= AVW'(avg_next);
        primed    <= 1'b1;
      end
      s2_shift <= start ? s_new : shift_reg;
      s2_data  <= s1_data;
      s2_side  <= s1_side;
      s3_side  <= s2_side;
      s4_side  <= s3_side;
    end
  end

  assign cur_shift = shift_reg;

  // stages 3-4: per-component shift/round then saturate; lane 1 = I, lane 0 = Q
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    exp_shifter_gen2_lane #(.DW(DATA_WIDTH), .MAX_SHIFT(MAX_SHIFT)) u_lane (
      .clk   (clk),
      .rst_n (sync_reset_n),
      .x     (s2_data[l]),
      .shift (s2_shift),
      .y     (y[l]),
      .clip  (clip[l])
    );
  end

  // first-word-fall-through output FIFO
  logic [2*DATA_WIDTH+TU:0] mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

  assign wr = vld_pipe[STAGES];
  assign rd = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = (count != '0);
  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = mem[rd_ptr];
  assign eob_tag = m_axis_tuser[TU-1];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {s4_side.last, s4_side.user, y};
  end

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SAT_COUNT_EN
  logic [16:0] sat_sum;
  assign sat_sum = {1'b0, sat_count} + 17'({1'b0, clip[0] & wr} + {1'b0, clip[1] & wr});

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n)   sat_count <= '0;
    else if (sat_clr)    sat_count <= '0;
    else if (sat_sum[16]) sat_count <= 16'hFFFF;
    else                 sat_count <= sat_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_exp_shifter_gen2.sv
// Bench for exp_shifter_gen2: directed and randomized blocks against a block-level
// model of the exponent average, shift, rounding and saturation rules.

module tb_exp_shifter_gen2;
  localparam int DW = 16, BW = 7, EW = 5, MS = 7, HR = 2, FB = 8, TU = 1 + EW + BW;

  logic clk = 1'b0;
  logic rst_n;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [2*DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [TU-1:0] s_axis_tuser, m_axis_tuser;
  logic [3:0] alpha_shift;
  logic bypass, m_axis_tvalid, m_axis_tlast, m_axis_tready, eob_tag;
  logic signed [5:0] cur_shift;
`ifdef SAT_COUNT_EN
  logic sat_clr;
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  exp_shifter_gen2 dut (
    .clk(clk), .sync_reset_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .alpha_shift(alpha_shift), .bypass(bypass),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .eob_tag(eob_tag), .cur_shift(cur_shift)
`ifdef SAT_COUNT_EN
    , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
  );

  typedef struct { logic [2*DW-1:0] d; logic [TU-1:0] u; logic l; } beat_t;
  beat_t q[$];
  int tests = 0, fails = 0;
  int m_avg, m_shift, m_sat, taken_cnt, rdy_mode;
  bit m_primed, taken, gaps, rnd_ctl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_shift(input string tag, input int expv);
    chk(tag, {58'd0, cur_shift}, {58'd0, 6'(expv)});
  endtask

  // {clipped, result} for one component under shift s
  function automatic logic [16:0] shp(input logic [15:0] x, input int s);
    longint v;
    v = longint'($signed(x));
    if (s >= 0) v = v * (longint'(1) << s);
    else        v = (v + (longint'(1) << (-s - 1))) >>> (-s);
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  function automatic logic [TU-1:0] mk_user(input logic tag, input int e, input int bin);
    logic [EW-1:0] ee;
    logic [BW-1:0] bb;
    ee = EW'(e);
    bb = BW'(bin);
    return {tag, ee, bb};
  endfunction

  task automatic model_take();
    int e, bin, sr, a;
    logic [16:0] ri, rq;
    e   = int'($signed(s_axis_tuser[BW +: EW]));
    bin = int'(s_axis_tuser[BW-1:0]);
    if (bin == 0) begin
      if (!m_primed) begin m_avg = e * (1 << FB); m_primed = 1; end
      sr = e - ((m_avg + (1 << (FB - 1))) >>> FB) - HR;
      if (sr > MS)  sr = MS;
      if (sr < -MS) sr = -MS;
      m_shift = bypass ? 0 : sr;
      a = (alpha_shift > 8) ? 8 : int'(alpha_shift);
      m_avg = m_avg + ((e * (1 << FB) - m_avg) >>> a);
    end
    ri = shp(s_axis_tdata[31:16], m_shift);
    rq = shp(s_axis_tdata[15:0], m_shift);
    m_sat = m_sat + int'(ri[16]) + int'(rq[16]);
    if (m_sat > 65535) m_sat = 65535;
    q.push_back('{d: {ri[15:0], rq[15:0]}, u: s_axis_tuser, l: s_axis_tlast});
  endtask

  // one clock: sample handshakes mid-cycle, then return #1 after the rising edge
  task automatic step();
    beat_t e;
    @(negedge clk);
    taken = 0;
    if (rst_n && s_axis_tvalid && s_axis_tready) begin
      model_take();
      taken = 1;
      taken_cnt++;
    end
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      chk("out_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_beat", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, {e.l, e.u, e.d});
        chk("eob_tag", 64'(eob_tag), 64'(e.u[TU-1]));
      end
    end
    @(posedge clk);
    #1;
    if (rdy_mode == 2) m_axis_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2*DW-1:0] d, input logic [TU-1:0] u, input logic l);
    if (gaps) repeat ($urandom_range(0, 2)) step();
    if (rnd_ctl) begin
      alpha_shift = 4'($urandom_range(0, 15));
      bypass      = ($urandom_range(0, 3) == 0);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    for (int i = 0; i < 400; i++) begin
      step();
      if (taken) break;
    end
    chk("send_taken", 64'(taken), 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_block(input int e, input int len, input int first, input bit rnd_data,
                            input logic [2*DW-1:0] d);
    for (int b = first; b < len; b++)
      send(rnd_data ? 32'($urandom) : d, mk_user(b == len - 1, e, b), b == len - 1);
  endtask

  task automatic drain();
    rdy_mode = 1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (q.size() == 0 && !m_axis_tvalid) break;
      step();
    end
    chk("drain_empty", 64'(q.size() == 0 && !m_axis_tvalid), 64'd1);
  endtask

  task automatic model_reset();
    q.delete();
    m_primed = 0;
    m_avg = 0;
    m_shift = 0;
    m_sat = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    alpha_shift = 4'd0; bypass = 1'b0; m_axis_tready = 1'b1; rdy_mode = 1; gaps = 0; rnd_ctl = 0;
    taken_cnt = 0;
`ifdef SAT_COUNT_EN
    sat_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk_shift("rst_cur_shift", 0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
`ifdef SAT_COUNT_EN
    chk("rst_sat_count", 64'(sat_count), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // first block: exp 5 primes avg, s=-2, 4-clk latency
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {16'h0100, 16'h0100};
    s_axis_tuser  = mk_user(1'b0, 5, 0);
    s_axis_tlast  = 1'b0;
    step();
    chk("first_taken", 64'(taken), 64'd1);
    s_axis_tvalid = 1'b0;
    step(); step(); step();
    chk("lat_not_yet", 64'(m_axis_tvalid), 64'd0);
    step();
    chk("lat_4", 64'(m_axis_tvalid), 64'd1);
    chk("first_I", 64'(m_axis_tdata[31:16]), 64'h0040);
    send_block(5, 8, 1, 0, {16'h0100, 16'h0100});
    chk_shift("blk_exp5", -2);
    drain();

    // exp 3 with alpha 0 (avg=3.0), then exp 6 with alpha 1: s=+1, avg -> 4.5
    send_block(3, 4, 0, 1, '0);
    alpha_shift = 4'd1;
    send_block(6, 4, 0, 1, '0);
    chk_shift("blk_exp6_a1", 1);
    alpha_shift = 4'd0;
    send_block(0, 3, 0, 1, '0);
    chk_shift("round_4p5", -7);

    // left shift +3 saturates both ways
    send_block(5, 4, 0, 0, {16'h1800, 16'hE000});
    chk_shift("left_3", 3);
    drain();
`ifdef SAT_COUNT_EN
    chk("sat_count", 64'(sat_count), 64'(m_sat));
`endif

    // right shift -1 rounding, then clamp of s_raw=-12
    send_block(6, 4, 0, 0, {16'h0003, 16'hFFFD});
    chk_shift("right_1", -1);
    send_block(-4, 2, 0, 1, '0);
    chk_shift("clamp_neg", -7);
    drain();
`ifdef SAT_COUNT_EN
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("sat_clr", 64'(sat_count), 64'd0);
    m_sat = 0;
`endif

    // randomized blocks, gaps, backpressure, mid-block control changes, missing bin 0
    rdy_mode = 2; gaps = 1; rnd_ctl = 1;
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, 8);
      send_block($urandom_range(0, 31), len, (len > 1 && $urandom_range(0, 7) == 0) ? 1 : 0, 1, '0);
    end
    gaps = 0; rnd_ctl = 0; bypass = 1'b0; alpha_shift = 4'd0;
    drain();
`ifdef SAT_COUNT_EN
    chk("sat_count_rand", 64'(sat_count), 64'(m_sat));
`endif

    // downstream stalled: exactly DEPTH-6 plus 4 in flight are accepted
    rdy_mode = 0; m_axis_tready = 1'b0;
    taken_cnt = 0; n = 0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      s_axis_tdata = 32'($urandom);
      s_axis_tuser = mk_user(n % 8 == 7, 2, n % 8);
      s_axis_tlast = (n % 8 == 7);
      step();
      if (taken) n++;
    end
    s_axis_tvalid = 1'b0;
    chk("bp_accepted", 64'(taken_cnt), 64'd30);
    chk("bp_tready_low", 64'(s_axis_tready), 64'd0);
    drain();
    chk("bp_tready_back", 64'(s_axis_tready), 64'd1);

    // reset mid-block with data buffered, then re-prime
    rdy_mode = 0; m_axis_tready = 1'b0;
    send_block(1, 4, 0, 1, '0);
    step(); step(); step(); step();
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tvalid", 64'(m_axis_tvalid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 1; m_axis_tready = 1'b1;
    alpha_shift = 4'd1;
    send_block(9, 4, 0, 1, '0);
    chk_shift("reprime", -2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
